// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, LATENCY wait cycles, then a one-cycle response pulse.
// Accept to resp_valid is LATENCY+1 cycles; req_ready is low while busy and there is no response backpressure.
// Little-endian RV32I byte/half/word accesses selected by funct3; misaligned or illegal funct3 reports resp_err.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_func3,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int WORDS = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        func3_q;
    logic [31:0]       wdata_q;
    logic              ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;
    logic              busy_q;
    logic [31:0]       mem_q [WORDS];

    logic [31:0] rd_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] wword_d;
    logic [31:0] rdata_d;
    logic        err_d;
    logic        do_access;

    assign rd_word   = mem_q[addr_q[ADDR_W-1:2]];
    assign byte_sel  = rd_word[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    assign do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);

    always_comb begin
        err_d   = 1'b0;
        be      = 4'b0000;
        rdata_d = 32'd0;
        wrep    = req_wdata_rep(func3_q[1:0], wdata_q);
        case (func3_q[1:0])
            2'b00: begin
                be      = 4'b0001 << addr_q[1:0];
                rdata_d = {{24{~func3_q[2] & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                err_d   = addr_q[0];
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                rdata_d = {{16{~func3_q[2] & half_sel[15]}}, half_sel};
            end
            2'b10: begin
                err_d   = (addr_q[1:0] != 2'b00);
                be      = 4'b1111;
                rdata_d = rd_word;
            end
            default: err_d = 1'b1;
        endcase
        // Unsigned variants exist only for byte/half loads; stores never take func3[2].
        if (func3_q[2] && (write_q || func3_q[1])) begin
            err_d = 1'b1;
        end
        if (err_d || write_q) begin
            rdata_d = 32'd0;
        end
        if (err_d || !write_q) begin
            be = 4'b0000;
        end
        for (int i = 0; i < 4; i++) begin
            wword_d[8*i +: 8] = be[i] ? wrep[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    function automatic logic [31:0] req_wdata_rep(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   req_wdata_rep = {4{d[7:0]}};
            2'b01:   req_wdata_rep = {2{d[15:0]}};
            default: req_wdata_rep = d;
        endcase
    endfunction

    // Array is deliberately not reset; a write only commits on the final WAIT edge.
    always_ff @(posedge clk) begin
        if (!rst && do_access && (be != 4'b0000)) begin
            mem_q[addr_q[ADDR_W-1:2]] <= wword_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            func3_q      <= 3'd0;
            wdata_q      <= 32'd0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        func3_q <= req_func3;
                        wdata_q <= req_wdata;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= S_WAIT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= rdata_d;
                        resp_err_q   <= err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                    busy_q       <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule
